// File: rtl/addr_rf_pkg.sv
// Shared sizing defaults, FSM encoding and entry layout for the kernel-offset
// address generator.
package addr_rf_pkg;

    localparam int unsigned ADDR_RF_G     = 4;
    localparam int unsigned ADDR_RF_DEPTH = 10;
    localparam int unsigned ADDR_RF_CW    = 7;
    localparam int unsigned ADDR_RF_SW    = 3;
    localparam int unsigned ADDR_RF_RW    = 3;
    localparam int unsigned ADDR_RF_KW    = 5;
    localparam int unsigned ADDR_RF_PW    = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_e;

    // Field order puts row in the LSBs so the struct overlays entry[0]=row.
    typedef struct packed {
        logic [ADDR_RF_CW-1:0] kernel;
        logic [ADDR_RF_CW-1:0] col;
        logic [ADDR_RF_CW-1:0] row;
    } entry_t;

endpackage

// File: rtl/addr_rf_group_sel.sv
// Maps an entry index onto its kernel group: the number of group end pointers
// already passed, capped at the last group.
module addr_rf_group_sel #(
    parameter int unsigned G  = 4,
    parameter int unsigned PW = 11,
    parameter int unsigned GW = 2
) (
    input  logic [G-1:0][PW-1:0] ptr_i,
    input  logic [PW-1:0]        idx_i,
    output logic [GW-1:0]        grp_o
);

    int unsigned cnt;

    always_comb begin
        cnt = 0;
        for (int unsigned j = 0; j < G; j++) begin
            if (ptr_i[j] <= idx_i) begin
                cnt = cnt + 1;
            end
        end
        if (cnt > G - 1) begin
            cnt = G - 1;
        end
        grp_o = GW'(cnt);
    end

endmodule

// File: rtl/addr_rf_gen.sv
// Sparse-kernel offset generator: walks a CSR group list, streams one
// {row, col, kernel} triple per cycle and records it in a register file.
// Optional feature: define ADDR_RF_CLAMP_EN for saturating subtraction and o_clamp.
module addr_rf_gen
    import addr_rf_pkg::*;
#(
    parameter int unsigned G     = ADDR_RF_G,
    parameter int unsigned DEPTH = ADDR_RF_DEPTH,
    parameter int unsigned CW    = ADDR_RF_CW,
    parameter int unsigned SW    = ADDR_RF_SW,
    parameter int unsigned RW    = ADDR_RF_RW,
    parameter int unsigned KW    = ADDR_RF_KW,
    parameter int unsigned PW    = ADDR_RF_PW
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_start,
    input  logic [CW-1:0]                 i_h,
    input  logic [CW-1:0]                 i_w,
    input  logic [SW-1:0]                 i_s,
    input  logic [G-1:0][RW-1:0]          i_r,
    input  logic [G-1:0][KW-1:0]          i_k,
    input  logic [G-1:0][PW-1:0]          i_ptr,
    input  logic [PW-1:0]                 i_length,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [2:0][CW-1:0]            o_entry,
    output logic [DEPTH-1:0][2:0][CW-1:0] o_rf,
    output logic [PW-1:0]                 o_count,
    output logic                          o_busy,
    output logic                          o_finish,
    output logic                          o_clamp
);

    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   h_q, w_q;
    logic [SW-1:0]                   s_q;
    logic [G-1:0][RW-1:0]            r_q;
    logic [G-1:0][KW-1:0]            k_q;
    logic [G-1:0][PW-1:0]            ptr_q;
    logic [PW-1:0]                   n_q, idx_q, count_q;
    logic [2:0][CW-1:0]              entry_q;
    logic [DEPTH-1:0][2:0][CW-1:0]   rf_q;

    logic                            load, hs, last;
    logic [CW-1:0]                   h_c, w_c;
    logic [SW-1:0]                   s_c;
    logic [G-1:0][RW-1:0]            r_c;
    logic [G-1:0][KW-1:0]            k_c;
    logic [G-1:0][PW-1:0]            ptr_c;
    logic [PW-1:0]                   sel_idx, n_load;
    logic [GW-1:0]                   grp;
    logic [CW-1:0]                   r_ext, s_ext;
    logic [2:0][CW-1:0]              entry_nx;
`ifdef ADDR_RF_CLAMP_EN
    logic                            sat_nx, sat_q, clamp_q;
`endif

    // During LOAD the first triple is built straight from the inputs so that
    // o_valid can rise in the very first RUN cycle.
    always_comb begin
        load    = (state_q == S_LOAD);
        h_c     = load ? i_h   : h_q;
        w_c     = load ? i_w   : w_q;
        s_c     = load ? i_s   : s_q;
        r_c     = load ? i_r   : r_q;
        k_c     = load ? i_k   : k_q;
        ptr_c   = load ? i_ptr : ptr_q;
        sel_idx = load ? '0 : idx_q + PW'(1);
        hs      = (state_q == S_RUN) && i_ready;
        last    = (idx_q == n_q - PW'(1));

        n_load = i_length;
        if (i_ptr[G-1] < n_load) n_load = i_ptr[G-1];
        if (PW'(DEPTH) < n_load) n_load = PW'(DEPTH);
    end

    addr_rf_group_sel #(
        .G  (G),
        .PW (PW),
        .GW (GW)
    ) u_group_sel (
        .ptr_i (ptr_c),
        .idx_i (sel_idx),
        .grp_o (grp)
    );

    always_comb begin
        r_ext       = CW'(r_c[grp]);
        s_ext       = CW'(s_c);
        entry_nx[2] = CW'(k_c[grp]);
`ifdef ADDR_RF_CLAMP_EN
        entry_nx[0] = (r_ext > h_c) ? '0 : h_c - r_ext;
        entry_nx[1] = (s_ext > w_c) ? '0 : w_c - s_ext;
        sat_nx      = (r_ext > h_c) || (s_ext > w_c);
`else
        entry_nx[0] = h_c - r_ext;
        entry_nx[1] = w_c - s_ext;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_LOAD;
            S_LOAD:  state_d = (n_load == '0) ? S_DONE : S_RUN;
            S_RUN:   if (hs && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            w_q     <= '0;
            s_q     <= '0;
            r_q     <= '0;
            k_q     <= '0;
            ptr_q   <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            count_q <= '0;
            entry_q <= '0;
            rf_q    <= '0;
`ifdef ADDR_RF_CLAMP_EN
            sat_q   <= 1'b0;
            clamp_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load) begin
                h_q     <= i_h;
                w_q     <= i_w;
                s_q     <= i_s;
                r_q     <= i_r;
                k_q     <= i_k;
                ptr_q   <= i_ptr;
                n_q     <= n_load;
                idx_q   <= '0;
                count_q <= '0;
                rf_q    <= '0;
                entry_q <= entry_nx;
`ifdef ADDR_RF_CLAMP_EN
                sat_q   <= sat_nx;
                clamp_q <= 1'b0;
`endif
            end else if (hs) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (idx_q == PW'(i)) rf_q[i] <= entry_q;
                end
                idx_q   <= idx_q + PW'(1);
                count_q <= count_q + PW'(1);
                if (!last) entry_q <= entry_nx;
`ifdef ADDR_RF_CLAMP_EN
                if (!last) sat_q <= sat_nx;
                if (sat_q) clamp_q <= 1'b1;
`endif
            end
        end
    end

    assign o_valid  = (state_q == S_RUN);
    assign o_busy   = (state_q != S_IDLE);
    assign o_finish = (state_q == S_DONE);
    assign o_entry  = entry_q;
    assign o_rf     = rf_q;
    assign o_count  = count_q;
`ifdef ADDR_RF_CLAMP_EN
    assign o_clamp  = clamp_q;
`else
    assign o_clamp  = 1'b0;
`endif

endmodule
